// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter for the write port of the async FIFO (w_clk domain).
//   One requester owns the port for a burst of up to BURST accepted beats.
//   Every write is gated on fifo_full, so the FIFO is never written while full.
//
// Parameters
//   NREQ   number of requesters (>=2)
//   fw     data width (matches the FIFO data width)
//   BURST  maximum accepted beats per grant (>=1)
//
// Ports
//   clk         write-domain clock
//   rst         asynchronous active-high reset
//   req         per-requester request, held with its data until acked
//   req_data    requester i data in bits [i*fw +: fw]
//   fifo_full   FIFO full flag
//   gnt         registered one-hot grant, all-zero when idle
//   ack         beat accepted this cycle (gnt & req & ~fifo_full)
//   fifo_wr     FIFO write strobe (|ack)
//   fifo_wdata  data of the granted requester, 0 when fifo_wr is low
//   busy        high while a requester owns the port
//
// Optional feature (macro ARB_STATS_EN)
//   stat_beats   saturating count of FIFO writes
//   stat_stalls  saturating count of cycles where the owner requests but
//                the FIFO is full
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int fw    = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*fw-1:0]   req_data,
    input  logic                 fifo_full,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 fifo_wr,
    output logic [fw-1:0]        fifo_wdata,
    output logic                 busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          stat_beats,
    output logic [15:0]          stat_stalls
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST - 1);
    localparam logic [PW-1:0] PTR_INIT  = PW'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [PW-1:0]     owner;
    logic [PW-1:0]     scan_base;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     pick_idx;
    logic              pick_vld;
    logic [NREQ-1:0]   pick_onehot;
    logic              own_ack;
    logic              own_req;
    logic [fw-1:0]     masked_data [NREQ];

    // Accept/data path is purely combinational from the registered grant.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign ack[gi]         = gnt_q[gi] & req[gi] & ~fifo_full;
            assign masked_data[gi] = ack[gi] ? req_data[gi*fw +: fw] : '0;
        end
    endgenerate

    assign fifo_wr = |ack;
    assign gnt     = gnt_q;
    assign busy    = (state_q == BUSY);

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            fifo_wdata = fifo_wdata | masked_data[i];
        end
    end

    // Encode the one-hot grant into the owner index.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner = PW'(i);
            end
        end
    end

    // Round-robin pick. While busy the scan starts after the current owner,
    // which is exactly the rr_ptr value being written on release, so the
    // re-arbitration happens in the releasing cycle without a bubble.
    // Scanning downwards lets the nearest candidate overwrite farther ones.
    always_comb begin
        scan_base = (state_q == BUSY) ? owner : rr_ptr_q;
        cand      = '0;
        pick_idx  = '0;
        pick_vld  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(scan_base) + k) % NREQ);
            if (req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_onehot = NREQ'(1) << pick_idx;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        own_ack    = ack[owner];
        own_req    = req[owner];
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d      = pick_onehot;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A full stall leaves ack low, so the budget is not consumed.
                if (own_ack) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                if ((own_ack && (beat_cnt_q == BEAT_LAST)) || !own_req) begin
                    rr_ptr_d   = owner;
                    beat_cnt_d = '0;
                    if (pick_vld) begin
                        gnt_d = pick_onehot;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= PTR_INIT;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_beats_q, stat_beats_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_beats_d  = stat_beats_q;
        stat_stalls_d = stat_stalls_q;
        if (fifo_wr && (stat_beats_q != 16'hFFFF)) begin
            stat_beats_d = stat_beats_q + 16'd1;
        end
        if (busy && own_req && fifo_full && (stat_stalls_q != 16'hFFFF)) begin
            stat_stalls_d = stat_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_beats_q  <= stat_beats_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. A behavioural model tracks the
//   current owner, beats taken in its burst and the last owner, and predicts
//   gnt/ack/fifo_wr/fifo_wdata/busy every cycle. Directed scenarios are
//   followed by randomized request/full traffic.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int FW    = 8;
    localparam int BURST = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*FW-1:0]   req_data;
    logic                 fifo_full;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic                 fifo_wr;
    logic [FW-1:0]        fifo_wdata;
    logic                 busy;
`ifdef ARB_STATS_EN
    logic [15:0]          stat_beats;
    logic [15:0]          stat_stalls;
`endif

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .fw    (FW),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state
    logic            rst_r;
    logic [NREQ-1:0] req_r;
    logic            full_r;
    logic [FW-1:0]   cur_data [NREQ];
    bit              hold_data;
    int              wr_cnt;

    // Reference model state
    int m_owner;   // -1 when idle
    int m_taken;   // accepted beats in the current burst
    int m_last;    // last owner, scan starts after it
    int m_beats;
    int m_stalls;
    int wait_b [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick(input int after);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (after + k) % NREQ;
            if (req_r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_taken  = 0;
        m_last   = NREQ - 1;
        m_beats  = 0;
        m_stalls = 0;
        for (int i = 0; i < NREQ; i++) wait_b[i] = 0;
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge should produce.
    task automatic step();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_ack;
        logic            e_wr;
        logic [FW-1:0]   e_wd;
        bit              rel;
        @(negedge clk);
        rst       = rst_r;
        req       = req_r;
        fifo_full = full_r;
        for (int i = 0; i < NREQ; i++) req_data[i*FW +: FW] = cur_data[i];
        #1;
        if (rst_r) model_reset();
`ifdef ARB_STATS_EN
        chk("stat_beats", 32'(stat_beats), 32'(m_beats));
        chk("stat_stalls", 32'(stat_stalls), 32'(m_stalls));
`endif
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_ack = full_r ? '0 : (e_gnt & req_r);
        e_wr  = (e_ack != '0);
        e_wd  = (e_wr && m_owner >= 0) ? cur_data[m_owner] : '0;

        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("wr_while_full", 32'(fifo_wr & fifo_full), 32'(0));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
        if (fifo_wr === 1'b1) wr_cnt++;

        if (!rst_r) begin
            // Starvation bound, measured in beats accepted from others.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_r[i]) wait_b[i] = 0;
                else if (e_ack[i]) begin
                    chk("starve", 32'(wait_b[i] <= (NREQ - 1) * BURST), 32'(1));
                    wait_b[i] = 0;
                end else if (e_wr) wait_b[i]++;
            end
            if (e_wr && m_beats < 65535) m_beats++;
            if (m_owner >= 0 && req_r[m_owner] && full_r && m_stalls < 65535) m_stalls++;

            if (m_owner < 0) begin
                m_owner = model_pick(m_last);
                m_taken = 0;
            end else begin
                if (e_ack[m_owner]) m_taken++;
                rel = (m_taken == BURST) || !req_r[m_owner];
                if (rel) begin
                    m_last  = m_owner;
                    m_owner = model_pick(m_last);
                    m_taken = 0;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i] && !hold_data) cur_data[i] = FW'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst_r  = 1'b1;
        req_r  = '0;
        full_r = 1'b0;
        step();
        rst_r  = 1'b0;
        hold_data = 1'b0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_r[i]) begin
                if ($urandom_range(0, 3) == 0) req_r[i] = 1'b1;
            end else if ($urandom_range(0, 31) == 0) begin
                req_r[i] = 1'b0;
            end
        end
        full_r = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        hold_data = 1'b0;
        wr_cnt    = 0;
        for (int i = 0; i < NREQ; i++) cur_data[i] = FW'($urandom);
        model_reset();

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        // Async reset in the middle of a burst of requester 2
        req_r = 4'b0100;
        step();
        step();
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_gnt", 32'(gnt), 32'(0));
        chk("t1_wr", 32'(fifo_wr), 32'(0));
        chk("t1_busy", 32'(busy), 32'(0));
        rst_r = 1'b1;
        step();
        rst_r = 1'b0;
        req_r = 4'b0101;
        step();
        step();
        chk("t1_first", 32'(gnt), 32'(4'b0001));

        // All requesting: bursts of BURST in order 0,1,2,3,0 with no gap
        do_reset();
        req_r = 4'b1111;
        step();
        wr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t2_order", 32'(gnt), 32'(1) << ((k / BURST) % NREQ));
            if (k == 15) chk("t2_writes", 32'(wr_cnt), 32'(16));
        end

        // Single requester 1 with fixed data
        do_reset();
        hold_data   = 1'b1;
        cur_data[1] = 8'hA5;
        req_r       = 4'b0010;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t3_gnt", 32'(gnt), 32'(4'b0010));
            chk("t3_wdata", 32'(fifo_wdata), 32'(8'hA5));
            chk("t3_wr", 32'(fifo_wr), 32'(1));
        end
        hold_data = 1'b0;

        // Full stall in the middle of a burst of requester 0
        do_reset();
        req_r = 4'b0001;
        step();
        step();
        full_r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_gnt_held", 32'(gnt), 32'(4'b0001));
        end
        full_r = 1'b0;
        step();
`ifdef ARB_STATS_EN
        chk("t4_stalls", 32'(stat_stalls), 32'(5));
`endif
        for (int k = 0; k < 4; k++) step();

        // Owner 3 drops its request after one beat while requester 1 waits
        do_reset();
        req_r = 4'b1000;
        step();
        req_r = 4'b1010;
        step();
        req_r = 4'b0010;
        step();
        step();
        chk("t5_gnt", 32'(gnt), 32'(4'b0010));

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
